// File: rtl/sort_pkg.sv
// Shared types and the compare primitive for the odd-even transposition sorting network.
package sort_pkg;

    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] wide_t;

    // Operands arrive already sign- or zero-extended to MAX_WIDTH by the caller.
    function automatic logic cas_gt(input wide_t a, input wide_t b, input logic signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage

// File: rtl/sort_stage.sv
// One registered compare-and-swap stage; even stages pair (0,1),(2,3)..., odd stages pair (1,2),(3,4)...
module sort_stage
    import sort_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANES  = 8,
    parameter int ODD    = 0,
    parameter int SIGNED = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic                   in_desc,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    output logic                   out_desc,
    output logic [LANES*WIDTH-1:0] out_data
);

    typedef logic [WIDTH-1:0] elem_t;

    elem_t                   a;
    elem_t                   b;
    logic                    swap;
    logic [LANES*WIDTH-1:0]  nxt;

    // Widening keeps the compare correct for any WIDTH up to MAX_WIDTH.
    function automatic wide_t widen(input elem_t x);
        wide_t w;
        w = '0;
        if (SIGNED != 0) begin
            w = {MAX_WIDTH{x[WIDTH-1]}};
        end
        w[WIDTH-1:0] = x;
        return w;
    endfunction

    always_comb begin
        nxt  = in_data;
        a    = '0;
        b    = '0;
        swap = 1'b0;
        for (int j = ODD; j + 1 < LANES; j += 2) begin
            a    = in_data[j*WIDTH +: WIDTH];
            b    = in_data[(j+1)*WIDTH +: WIDTH];
            swap = in_desc ? cas_gt(widen(b), widen(a), SIGNED != 0)
                           : cas_gt(widen(a), widen(b), SIGNED != 0);
            if (swap) begin
                nxt[j*WIDTH +: WIDTH]     = b;
                nxt[(j+1)*WIDTH +: WIDTH] = a;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_desc  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_desc  <= in_desc;
            out_data  <= nxt;
        end
    end

endmodule

// File: rtl/sort_net_pp.sv
// Fully pipelined N-lane odd-even transposition sorter with per-vector mode and global-stall flow control.
module sort_net_pp
    import sort_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANES  = 8,
    parameter int SIGNED = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_desc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_desc
);

    localparam int LATENCY = LANES;

    logic [LANES*WIDTH-1:0] stage_data  [LATENCY+1];
    logic                   stage_valid [LATENCY+1];
    logic                   stage_desc  [LATENCY+1];
    logic                   advance;

    // The whole pipe moves together; it only freezes when a presented vector is refused.
    assign advance        = ~out_valid | out_ready;
    assign in_ready       = advance;
    assign stage_data[0]  = in_data;
    assign stage_valid[0] = in_valid;
    assign stage_desc[0]  = in_desc;

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        sort_stage #(
            .WIDTH  (WIDTH),
            .LANES  (LANES),
            .ODD    (s % 2),
            .SIGNED (SIGNED)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (stage_valid[s]),
            .in_desc   (stage_desc[s]),
            .in_data   (stage_data[s]),
            .out_valid (stage_valid[s+1]),
            .out_desc  (stage_desc[s+1]),
            .out_data  (stage_data[s+1])
        );
    end

    assign out_valid = stage_valid[LATENCY];
    assign out_desc  = stage_desc[LATENCY];
    assign out_data  = stage_data[LATENCY];

endmodule

// File: tb/tb_sort_net_pp.sv
// Directed bench for sort_net_pp: 4 lanes x 8 bits, signed and unsigned builds driven side by side.
module tb_sort_net_pp;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_desc;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, s_out_desc;
    logic [31:0] s_out_data;
    logic        u_in_ready, u_out_valid, u_out_desc;
    logic [31:0] u_out_data;

    int pass_count  = 0;
    int fail_count  = 0;
    int total_count = 0;

    logic [31:0] tin    [8];
    logic        tdesc  [8];
    logic [31:0] texp_s [8];
    logic [31:0] texp_u [8];

    logic [32:0] q_s [$];
    logic [32:0] q_u [$];

    sort_net_pp #(.WIDTH(8), .LANES(4), .SIGNED(1)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .out_desc  (s_out_desc)
    );

    sort_net_pp #(.WIDTH(8), .LANES(4), .SIGNED(0)) dut_u (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (u_out_valid),
        .out_ready (out_ready),
        .out_data  (u_out_data),
        .out_desc  (u_out_desc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                          input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference sort: plain selection sort over integer keys.
    function automatic logic [31:0] sort4(input logic [31:0] d, input logic dsc, input logic sgn);
        int          k [4];
        int          t;
        logic [7:0]  e;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            e    = d[i*8 +: 8];
            k[i] = sgn ? int'({{24{e[7]}}, e}) : int'({24'h0, e});
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (dsc ? (k[j] > k[i]) : (k[j] < k[i])) begin
                    t    = k[i];
                    k[i] = k[j];
                    k[j] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            t          = k[i];
            r[i*8 +: 8] = t[7:0];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic dsc, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_desc   = dsc;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tin[0] = pack4(8'h03, 8'h01, 8'h04, 8'h02); tdesc[0] = 1'b0;
        texp_s[0] = pack4(8'h01, 8'h02, 8'h03, 8'h04); texp_u[0] = texp_s[0];
        tin[1] = pack4(8'h03, 8'h01, 8'h04, 8'h02); tdesc[1] = 1'b1;
        texp_s[1] = pack4(8'h04, 8'h03, 8'h02, 8'h01); texp_u[1] = texp_s[1];
        tin[2] = pack4(8'hFF, 8'h05, 8'h80, 8'h00); tdesc[2] = 1'b0;
        texp_s[2] = pack4(8'h80, 8'hFF, 8'h00, 8'h05); texp_u[2] = pack4(8'h00, 8'h05, 8'h80, 8'hFF);
        tin[3] = pack4(8'hFF, 8'h05, 8'h80, 8'h00); tdesc[3] = 1'b1;
        texp_s[3] = pack4(8'h05, 8'h00, 8'hFF, 8'h80); texp_u[3] = pack4(8'hFF, 8'h80, 8'h05, 8'h00);
        tin[4] = pack4(8'h07, 8'h07, 8'h02, 8'h07); tdesc[4] = 1'b0;
        texp_s[4] = pack4(8'h02, 8'h07, 8'h07, 8'h07); texp_u[4] = texp_s[4];
        tin[5] = pack4(8'h7F, 8'h80, 8'h01, 8'hFE); tdesc[5] = 1'b1;
        texp_s[5] = pack4(8'h7F, 8'h01, 8'hFE, 8'h80); texp_u[5] = pack4(8'hFE, 8'h80, 8'h7F, 8'h01);
        tin[6] = pack4(8'h10, 8'h20, 8'h30, 8'h40); tdesc[6] = 1'b0;
        texp_s[6] = pack4(8'h10, 8'h20, 8'h30, 8'h40); texp_u[6] = texp_s[6];
        tin[7] = pack4(8'h10, 8'h20, 8'h30, 8'h40); tdesc[7] = 1'b1;
        texp_s[7] = pack4(8'h40, 8'h30, 8'h20, 8'h10); texp_u[7] = texp_s[7];

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #12;
        checkOutput("rst_out_valid", s_out_valid, 0);
        checkOutput("rst_out_data", s_out_data, 0);
        checkOutput("rst_out_desc", s_out_desc, 0);
        checkOutput("rst_u_out_valid", u_out_valid, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", s_in_ready, 1);

        // Single ascending vector, latency of exactly 4
        step();
        applyStimulus(1'b1, tin[0], 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        step();
        checkOutput("lat_early_valid", s_out_valid, 0);
        step();
        checkOutput("lat_valid", s_out_valid, 1);
        checkOutput("lat_data_s", s_out_data, texp_s[0]);
        checkOutput("lat_desc", s_out_desc, 0);
        checkOutput("lat_data_u", u_out_data, texp_u[0]);
        step();
        checkOutput("lat_bubble", s_out_valid, 0);

        // Back-to-back stream alternating asc/desc
        for (int c = 0; c < 12; c++) begin
            if (c < 8) applyStimulus(1'b1, tin[c], tdesc[c], 1'b1);
            else       applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            step();
            if (c == 2) checkOutput("stream_pre_valid", s_out_valid, 0);
            if (c >= 3 && c <= 10) begin
                checkOutput($sformatf("stream_valid_%0d", c - 3), s_out_valid, 1);
                checkOutput($sformatf("stream_data_s_%0d", c - 3), s_out_data, texp_s[c-3]);
                checkOutput($sformatf("stream_data_u_%0d", c - 3), u_out_data, texp_u[c-3]);
                checkOutput($sformatf("stream_desc_%0d", c - 3), s_out_desc, tdesc[c-3]);
                checkOutput($sformatf("stream_desc_u_%0d", c - 3), u_out_desc, tdesc[c-3]);
            end
            if (c == 11) checkOutput("stream_post_valid", s_out_valid, 0);
        end

        // Backpressure: hold the head vector for 3 cycles
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, tin[c], tdesc[c], 1'b1);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("bp_in_ready", s_in_ready, 0);
            checkOutput("bp_u_in_ready", u_in_ready, 0);
            checkOutput("bp_valid", s_out_valid, 1);
            checkOutput("bp_data_hold", s_out_data, texp_s[0]);
            checkOutput("bp_desc_hold", s_out_desc, tdesc[0]);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("bp_drain_valid_%0d", k), s_out_valid, 1);
            checkOutput($sformatf("bp_drain_s_%0d", k), s_out_data, texp_s[k]);
            checkOutput($sformatf("bp_drain_u_%0d", k), u_out_data, texp_u[k]);
            checkOutput($sformatf("bp_drain_desc_%0d", k), s_out_desc, tdesc[k]);
            step();
        end
        checkOutput("bp_empty", s_out_valid, 0);

        // Random valid/ready traffic against the reference sort, then drain
        for (int c = 0; c < 340; c++) begin
            logic        v;
            logic        rd;
            logic        ds;
            logic [31:0] d;
            v  = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            rd = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
            ds = 1'($urandom_range(0, 1));
            d  = $urandom;
            applyStimulus(v, d, ds, rd);
            #1;
            if (s_out_valid && out_ready) begin
                if (q_s.size() == 0) checkOutput("rand_s_extra", s_out_valid, 0);
                else checkOutput("rand_s", {s_out_desc, s_out_data}, q_s.pop_front());
            end
            if (u_out_valid && out_ready) begin
                if (q_u.size() == 0) checkOutput("rand_u_extra", u_out_valid, 0);
                else checkOutput("rand_u", {u_out_desc, u_out_data}, q_u.pop_front());
            end
            if (v && s_in_ready) q_s.push_back({ds, sort4(d, ds, 1'b1)});
            if (v && u_in_ready) q_u.push_back({ds, sort4(d, ds, 1'b0)});
            step();
        end
        checkOutput("rand_drain_s", q_s.size(), 0);
        checkOutput("rand_drain_u", q_u.size(), 0);

        // Asynchronous reset with vectors in flight
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, tin[4+c], tdesc[4+c], 1'b1);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", s_out_valid, 0);
        checkOutput("arst_u_valid", u_out_valid, 0);
        checkOutput("arst_data", s_out_data, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            checkOutput($sformatf("arst_no_stale_%0d", c), s_out_valid, 0);
        end
        applyStimulus(1'b1, tin[2], tdesc[2], 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        step();
        checkOutput("arst_lat_early", s_out_valid, 0);
        step();
        checkOutput("arst_lat_valid", s_out_valid, 1);
        checkOutput("arst_data_s", s_out_data, texp_s[2]);
        checkOutput("arst_data_u", u_out_data, texp_u[2]);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
